div_iter: RTL and testbench
===========================

Name: div_iter

Overview:
- Next-generation iterative integer divider/remainder unit for the integer execution cluster.
- Parametrised in datapath width and input queue depth; radix-4 (2 quotient bits/clock) with early-out.
- Accepts a new request while a divide is running, and returns results over a valid/ready handshake so the write port can stall it.
- Implements RISC-V M div/divu/rem/remu and the W forms, with per-entry commit-kill.

Parameters:
- RV, 64, datapath width (32 or 64).
- NHART, 1, number of harts.
- LNHART, 1, hart-index width (min 1).
- NCOMMIT, 32, commit-register count.
- LNCOMMIT, 5, log2(NCOMMIT).
- QDEPTH, 2, input queue entries (1..4).
- EARLY_OUT, 1, 1 = skip leading-zero dividend bit pairs at setup.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge)
- rv32  in  1  32-bit mode: every op treated as a W op
- req_valid  in  1  request present
- req_ready  out  1  queue not full
- req_w  in  1  W op (operands are the low 32 bits)
- req_rem  in  1  1 = remainder, 0 = quotient
- req_sgn  in  1  1 = signed
- req_rd  in  LNCOMMIT  destination commit register
- req_makes_rd  in  1  result is written
- req_hart  in  LNHART  hart
- r1, r2  in  RV  dividend, divisor
- commit_kill  in  NCOMMIT  kill vector indexed by rd
- res_valid  out  1  result available
- res_ready  in  1  write port accepts result
- result  out  RV  quotient/remainder
- res_rd  out  LNCOMMIT  rd of result
- res_makes_rd  out  NHART  one-hot write enable (hart bit = makes_rd && !killed)
- busy  out  1  queue non-empty or FSM not IDLE
- busy_rd  out  LNCOMMIT  rd of the entry in the FSM

Behaviour:
- Reset: queue empty; FSM IDLE. Outputs: req_ready=1, res_valid=0, res_makes_rd=0, busy=0, result=0, res_rd=0, busy_rd=0.
- Queue:
  - Push on req_valid&&req_ready.
  - req_ready = !full. No same-cycle push-on-pop bypass when full.
  - A request whose rd is killed in its push cycle is not pushed.
  - Each cycle, queued entries with commit_kill[rd]=1 are removed and the remaining entries compacted; ordering is preserved.
- FSM: IDLE -> SETUP -> ITER -> [FIXUP] -> DONE -> IDLE.
  - IDLE pops the queue head when the queue is non-empty.
  - SETUP:
    - W ops: operands are the low 32 bits, sign- or zero-extended by req_sgn.
    - Take absolute values when signed.
    - negq = sgn && (a<0 XOR b<0) && b!=0; negr = sgn && a<0.
    - Iteration count: n = ceil(significant bits of |a| / 2) when EARLY_OUT=1, min 1; otherwise n = width/2 (32 for 64-bit, 16 for W).
    - Divisor==0: n=0, straight to DONE with quotient = all ones and remainder = dividend (before negation).
  - ITER: one radix-4 step per cycle, comparing against d, 2d and 3d, with 3d precomputed in SETUP. Runs for n cycles.
  - FIXUP: one cycle, entered only if the selected result must be negated (negq for div, negr for rem).
  - DONE:
    - res_valid=1 with result, res_rd and res_makes_rd held stable until res_ready.
    - W results are sign-extended from bit 31.
    - Transfer happens on res_valid&&res_ready; the FSM goes to IDLE and can pop the next entry in the following cycle.
- Latency: with acceptance at edge T into an empty unit, res_valid is first high after edge T+2+n+f, where f = 1 if FIXUP is taken, else 0.
- Overflow: signed MIN/-1 gives quotient = MIN and remainder = 0. This is the natural result of the algorithm and needs no special case.
- Kill:
  - commit_kill[busy_rd] in SETUP, ITER or FIXUP aborts to IDLE next cycle with no result.
  - In DONE, res_valid drops the next cycle and no transfer is counted.
  - res_makes_rd is masked combinationally by commit_kill[res_rd].
- Reset mid-operation: all state discarded; no result is produced.

Decomposition:
- Shared package div_pkg:
  - FSM state enum (IDLE, SETUP, ITER, FIXUP, DONE).
  - Queue-entry struct {w, rem, sgn, rd, makes_rd, hart, r1, r2}.
  - Constants ITER64=32, ITER32=16.
- One sub-module, div_fifo: parametrised QDEPTH queue with kill-by-rd compaction.
- Datapath and FSM stay in div_iter.

Test Plan:
- Unsigned 64-bit, r1=100, r2=7, div then rem, res_ready=1 -> results 14 and 2. Each res_valid appears 6 cycles after acceptance (n=4, f=0).
- Signed, r1=-7, r2=2 -> div gives 0xFFFF_FFFF_FFFF_FFFD and rem gives 0xFFFF_FFFF_FFFF_FFFF. Latency 5 (n=2, f=1).
- Divide by zero, r1=5, r2=0 -> divu gives all ones and remu gives 5. Latency 2.
- Overflow:
  - Signed 64-bit MIN / -1 -> quotient 0x8000_0000_0000_0000, remainder 0.
  - divw with r1=0xFFFF_FFFF_8000_0000, r2=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000.
- Queue and back-pressure, QDEPTH=2:
  - Issue 3 requests back to back -> req_ready low once the FSM holds one entry and two are queued.
  - Hold res_ready=0 for 10 cycles -> result stable throughout.
  - Results emerge in issue order.
- Kill:
  - Kill the in-flight rd mid-ITER -> no res_valid, and the next queued entry starts.
  - Kill a queued rd -> that entry never produces a result.
  - Kill during DONE -> res_makes_rd is 0 that cycle.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative radix-4 divider.
package div_pkg;

  localparam int ITER64 = 32;
  localparam int ITER32 = 16;

  // Entry field widths cover the default build; raise these when instantiating with wider rd/hart indices.
  localparam int DIV_XLEN   = 64;
  localparam int DIV_RD_W   = 5;
  localparam int DIV_HART_W = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ITER  = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } div_state_e;

  typedef struct packed {
    logic                  w;
    logic                  rem;
    logic                  sgn;
    logic [DIV_RD_W-1:0]   rd;
    logic                  makes_rd;
    logic [DIV_HART_W-1:0] hart;
    logic [DIV_XLEN-1:0]   r1;
    logic [DIV_XLEN-1:0]   r2;
  } div_req_t;

endpackage

// File: rtl/div_fifo.sv
// Small in-order request queue; entries whose rd is killed drop out and the rest close ranks.
module div_fifo
  import div_pkg::*;
#(
  parameter int QDEPTH   = 2,
  parameter int NCOMMIT  = 32,
  parameter int LNCOMMIT = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCOMMIT-1:0] commit_kill,
  input  logic               push,
  input  div_req_t           push_ent,
  input  logic               pop,
  output logic               full,
  output logic               nonempty,
  output logic               head_valid,
  output div_req_t           head
);

  localparam int CW = $clog2(QDEPTH + 1);

  div_req_t        ent_q [QDEPTH];
  div_req_t        ent_d [QDEPTH];
  div_req_t        comp  [QDEPTH];
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    int nk;
    int nn;
    nk = 0;
    for (int i = 0; i < QDEPTH; i++) comp[i] = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (i < int'(cnt_q) && !commit_kill[ent_q[i].rd[LNCOMMIT-1:0]]) begin
        comp[nk] = ent_q[i];
        nk = nk + 1;
      end
    end
    head       = comp[0];
    head_valid = (nk != 0);
    ent_d      = comp;
    nn         = nk;
    if (pop && nk != 0) begin
      for (int i = 0; i < QDEPTH - 1; i++) ent_d[i] = comp[i+1];
      ent_d[QDEPTH-1] = '0;
      nn = nk - 1;
    end
    // A request killed in its own push cycle never enters the queue.
    if (push && !commit_kill[push_ent.rd[LNCOMMIT-1:0]] && nn < QDEPTH) begin
      ent_d[nn] = push_ent;
      nn = nn + 1;
    end
    cnt_d = CW'(nn);
  end

  assign full     = (cnt_q == CW'(QDEPTH));
  assign nonempty = (cnt_q != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      for (int i = 0; i < QDEPTH; i++) ent_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < QDEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-4 RISC-V M divider/remainder with early-out, input queue and commit-kill.
module div_iter
  import div_pkg::*;
#(
  parameter int RV        = 64,
  parameter int NHART     = 1,
  parameter int LNHART    = 1,
  parameter int NCOMMIT   = 32,
  parameter int LNCOMMIT  = 5,
  parameter int QDEPTH    = 2,
  parameter int EARLY_OUT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rv32,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_w,
  input  logic                req_rem,
  input  logic                req_sgn,
  input  logic [LNCOMMIT-1:0] req_rd,
  input  logic                req_makes_rd,
  input  logic [LNHART-1:0]   req_hart,
  input  logic [RV-1:0]       r1,
  input  logic [RV-1:0]       r2,
  input  logic [NCOMMIT-1:0]  commit_kill,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [RV-1:0]       result,
  output logic [LNCOMMIT-1:0] res_rd,
  output logic [NHART-1:0]    res_makes_rd,
  output logic                busy,
  output logic [LNCOMMIT-1:0] busy_rd
);

  localparam int CNTW = $clog2(RV / 2 + 1);

  function automatic logic [RV-1:0] ext32(input logic [31:0] v, input logic s);
    logic [RV-1:0] r;
    r       = {RV{s & v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  div_state_e          st_q, st_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [RV-1:0]       a_q, a_d, d_q, d_d, q_q, q_d, r_q, r_d;
  logic [RV-1:0]       op1_q, op1_d, op2_q, op2_d;
  logic [RV+1:0]       d3_q, d3_d;
  logic                w_q, w_d, rem_q, rem_d, sgn_q, sgn_d, mk_q, mk_d;
  logic                negq_q, negq_d, negr_q, negr_d;
  logic [LNCOMMIT-1:0] rd_q, rd_d;
  logic [LNHART-1:0]   hart_q, hart_d;

  div_req_t push_ent, head;
  logic     push, pop, head_valid, fifo_full, fifo_nonempty;

  always_comb begin
    push_ent          = '0;
    push_ent.w        = req_w;
    push_ent.rem      = req_rem;
    push_ent.sgn      = req_sgn;
    push_ent.rd       = DIV_RD_W'(req_rd);
    push_ent.makes_rd = req_makes_rd;
    push_ent.hart     = DIV_HART_W'(req_hart);
    push_ent.r1       = DIV_XLEN'(r1);
    push_ent.r2       = DIV_XLEN'(r2);
  end

  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;

  div_fifo #(
    .QDEPTH   (QDEPTH),
    .NCOMMIT  (NCOMMIT),
    .LNCOMMIT (LNCOMMIT)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .commit_kill (commit_kill),
    .push        (push),
    .push_ent    (push_ent),
    .pop         (pop),
    .full        (fifo_full),
    .nonempty    (fifo_nonempty),
    .head_valid  (head_valid),
    .head        (head)
  );

  // Operand conditioning for SETUP
  logic [RV-1:0] a_ext, b_ext, a_abs, b_abs, a_sh;
  logic [RV+1:0] d3;
  logic          a_neg, b_neg;
  int            msb, n_it;

  always_comb begin
    a_ext = w_q ? ext32(op1_q[31:0], sgn_q) : op1_q;
    b_ext = w_q ? ext32(op2_q[31:0], sgn_q) : op2_q;
    a_neg = sgn_q & a_ext[RV-1];
    b_neg = sgn_q & b_ext[RV-1];
    a_abs = a_neg ? -a_ext : a_ext;
    b_abs = b_neg ? -b_ext : b_ext;
    msb   = 0;
    for (int i = 0; i < RV; i++) if (a_abs[i]) msb = i + 1;
    if (EARLY_OUT != 0) n_it = (msb + 1) / 2;
    else                n_it = w_q ? ITER32 : ((RV == 64) ? ITER64 : ITER32);
    if (n_it == 0) n_it = 1;
    // Left-align so the next dividend digit always sits in the top two bits.
    a_sh  = a_abs << (RV - 2 * n_it);
    d3    = {2'b00, b_abs} + {1'b0, b_abs, 1'b0};
  end

  // One radix-4 restoring step
  logic [RV+1:0] rr, rn, dd1, dd2;
  logic [1:0]    dig;

  always_comb begin
    rr  = {r_q, a_q[RV-1 -: 2]};
    dd1 = {2'b00, d_q};
    dd2 = {1'b0, d_q, 1'b0};
    if (rr >= d3_q) begin
      dig = 2'd3; rn = rr - d3_q;
    end else if (rr >= dd2) begin
      dig = 2'd2; rn = rr - dd2;
    end else if (rr >= dd1) begin
      dig = 2'd1; rn = rr - dd1;
    end else begin
      dig = 2'd0; rn = rr;
    end
  end

  logic kill_cur, need_fix;
  assign kill_cur = commit_kill[rd_q];
  assign need_fix = rem_q ? negr_q : negq_q;

  always_comb begin
    st_d   = st_q;   cnt_d  = cnt_q;
    a_d    = a_q;    d_d    = d_q;    d3_d   = d3_q;
    q_d    = q_q;    r_d    = r_q;
    op1_d  = op1_q;  op2_d  = op2_q;
    w_d    = w_q;    rem_d  = rem_q;  sgn_d  = sgn_q;  mk_d = mk_q;
    negq_d = negq_q; negr_d = negr_q;
    rd_d   = rd_q;   hart_d = hart_q;
    pop    = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (head_valid) begin
          pop    = 1'b1;
          w_d    = head.w | rv32 | 1'(RV == 32);
          rem_d  = head.rem;
          sgn_d  = head.sgn;
          mk_d   = head.makes_rd;
          rd_d   = head.rd[LNCOMMIT-1:0];
          hart_d = head.hart[LNHART-1:0];
          op1_d  = head.r1[RV-1:0];
          op2_d  = head.r2[RV-1:0];
          st_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (kill_cur) begin
          st_d = ST_IDLE;
        end else if (b_abs == '0) begin
          q_d    = '1;
          r_d    = a_ext;
          negq_d = 1'b0;
          negr_d = 1'b0;
          st_d   = ST_DONE;
        end else begin
          q_d    = '0;
          r_d    = '0;
          a_d    = a_sh;
          d_d    = b_abs;
          d3_d   = d3;
          cnt_d  = CNTW'(n_it);
          negq_d = sgn_q & (a_neg ^ b_neg);
          negr_d = a_neg;
          st_d   = ST_ITER;
        end
      end
      ST_ITER: begin
        if (kill_cur) begin
          st_d = ST_IDLE;
        end else begin
          r_d   = rn[RV-1:0];
          q_d   = {q_q[RV-3:0], dig};
          a_d   = a_q << 2;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNTW'(1)) st_d = need_fix ? ST_FIXUP : ST_DONE;
        end
      end
      ST_FIXUP: begin
        if (kill_cur) begin
          st_d = ST_IDLE;
        end else begin
          if (rem_q) r_d = -r_q;
          else       q_d = -q_q;
          st_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_ready || kill_cur) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q   <= ST_IDLE; cnt_q  <= '0;
      a_q    <= '0;      d_q    <= '0;  d3_q  <= '0;
      q_q    <= '0;      r_q    <= '0;
      op1_q  <= '0;      op2_q  <= '0;
      w_q    <= 1'b0;    rem_q  <= 1'b0; sgn_q <= 1'b0; mk_q <= 1'b0;
      negq_q <= 1'b0;    negr_q <= 1'b0;
      rd_q   <= '0;      hart_q <= '0;
    end else begin
      st_q   <= st_d;    cnt_q  <= cnt_d;
      a_q    <= a_d;     d_q    <= d_d;  d3_q  <= d3_d;
      q_q    <= q_d;     r_q    <= r_d;
      op1_q  <= op1_d;   op2_q  <= op2_d;
      w_q    <= w_d;     rem_q  <= rem_d; sgn_q <= sgn_d; mk_q <= mk_d;
      negq_q <= negq_d;  negr_q <= negr_d;
      rd_q   <= rd_d;    hart_q <= hart_d;
    end
  end

  logic [RV-1:0] sel;
  assign sel       = rem_q ? r_q : q_q;
  assign res_valid = (st_q == ST_DONE);
  assign result    = res_valid ? (w_q ? ext32(sel[31:0], 1'b1) : sel) : '0;
  assign res_rd    = rd_q;
  assign busy_rd   = rd_q;
  assign busy      = fifo_nonempty || (st_q != ST_IDLE);

  always_comb begin
    for (int h = 0; h < NHART; h++)
      res_makes_rd[h] = res_valid && mk_q && !kill_cur && (hart_q == LNHART'(h));
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed checks of div_iter: arithmetic, latency, queueing, back-pressure, kill and reset.
module tb_div_iter;

  logic        clk = 1'b0, reset = 1'b0, rv32 = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic        req_w = 1'b0, req_rem = 1'b0, req_sgn = 1'b0, req_makes_rd = 1'b0;
  logic [4:0]  req_rd = '0;
  logic [0:0]  req_hart = '0;
  logic [63:0] r1 = '0, r2 = '0, result;
  logic [31:0] commit_kill = '0;
  logic        res_valid, res_ready = 1'b1, busy;
  logic [4:0]  res_rd, busy_rd;
  logic [0:0]  res_makes_rd;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  div_iter dut (
    .clk          (clk),
    .reset        (reset),
    .rv32         (rv32),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_w        (req_w),
    .req_rem      (req_rem),
    .req_sgn      (req_sgn),
    .req_rd       (req_rd),
    .req_makes_rd (req_makes_rd),
    .req_hart     (req_hart),
    .r1           (r1),
    .r2           (r2),
    .commit_kill  (commit_kill),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .result       (result),
    .res_rd       (res_rd),
    .res_makes_rd (res_makes_rd),
    .busy         (busy),
    .busy_rd      (busy_rd)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic rem, input logic sgn, input logic [4:0] rd,
                       input logic [63:0] a, input logic [63:0] b);
    int g;
    g = 0;
    while (!req_ready && g < 100) begin tick(); g++; end
    if (!req_ready) chk("issue_ready_timeout", 64'd0, 64'd1);
    req_valid = 1'b1; req_w = w; req_rem = rem; req_sgn = sgn; req_rd = rd;
    req_makes_rd = 1'b1; r1 = a; r2 = b;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag, output int lat);
    lat = 0;
    while (!res_valid && lat < 200) begin tick(); lat++; end
    if (!res_valid) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic expect_res(input string tag, input logic [63:0] exp, input logic [4:0] rd);
    int lat;
    wait_res(tag, lat);
    chk(tag, result, exp);
    chk({tag, "_rd"}, 64'(res_rd), 64'(rd));
    res_ready = 1'b1;
    tick();
  endtask

  task automatic run_op(input string tag, input logic w, input logic rem, input logic sgn,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_lat);
    int lat;
    res_ready = 1'b1;
    issue(w, rem, sgn, 5'd1, a, b);
    wait_res(tag, lat);
    chk(tag, result, exp);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_we"}, 64'(res_makes_rd), 64'd1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen, stable;
    int   lat;

    tick(); tick();
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_res_rd", 64'(res_rd), 64'd0);
    chk("rst_busy_rd", 64'(busy_rd), 64'd0);
    chk("rst_we", 64'(res_makes_rd), 64'd0);
    reset = 1'b1;
    tick();

    // tag, w, rem, sgn, r1, r2, expected, latency
    run_op("divu_100_7",  1'b0, 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 6);
    run_op("remu_100_7",  1'b0, 1'b1, 1'b0, 64'd100, 64'd7, 64'd2,  6);
    run_op("div_m7_2",    1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 5);
    run_op("rem_m7_2",    1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 5);
    run_op("divu_5_0",    1'b0, 1'b0, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    run_op("remu_5_0",    1'b0, 1'b1, 1'b0, 64'd5, 64'd0, 64'd5, 2);
    run_op("div_min_m1",  1'b0, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 34);
    run_op("rem_min_m1",  1'b0, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'd0, 35);
    run_op("divw_ovf",    1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 18);
    run_op("divuw_10_3",  1'b1, 1'b0, 1'b0, 64'h0000_0001_0000_000A, 64'd3, 64'd3, 4);
    run_op("remuw_10_3",  1'b1, 1'b1, 1'b0, 64'h0000_0001_0000_000A, 64'd3, 64'd1, 4);

    // Queue fill and result back-pressure
    res_ready = 1'b0;
    issue(1'b0, 1'b0, 1'b0, 5'd1, 64'd100, 64'd7);
    issue(1'b0, 1'b1, 1'b0, 5'd2, 64'd100, 64'd7);
    issue(1'b0, 1'b0, 1'b0, 5'd3, 64'd50,  64'd5);
    chk("bp_full_ready", 64'(req_ready), 64'd0);
    chk("bp_busy_rd", 64'(busy_rd), 64'd1);
    wait_res("bp_a", lat);
    chk("bp_a", result, 64'd14);
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (!res_valid || result !== 64'd14 || res_rd !== 5'd1) stable = 1'b0;
    end
    chk("bp_stable", 64'(stable), 64'd1);
    res_ready = 1'b1;
    tick();
    expect_res("bp_b", 64'd2,  5'd2);
    expect_res("bp_c", 64'd10, 5'd3);

    // Kill the running entry mid-ITER; the queued one must follow
    issue(1'b0, 1'b0, 1'b0, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
    issue(1'b0, 1'b0, 1'b0, 5'd5, 64'd100, 64'd7);
    tick(); tick();
    chk("ki_busy_rd", 64'(busy_rd), 64'd4);
    commit_kill[4] = 1'b1;
    tick();
    commit_kill = '0;
    expect_res("ki_next", 64'd14, 5'd5);

    // Kill a queued entry
    issue(1'b0, 1'b0, 1'b0, 5'd6, 64'd100, 64'd7);
    issue(1'b0, 1'b1, 1'b0, 5'd7, 64'd100, 64'd7);
    issue(1'b0, 1'b0, 1'b0, 5'd8, 64'd50,  64'd5);
    commit_kill[7] = 1'b1;
    tick();
    commit_kill = '0;
    expect_res("kq_a", 64'd14, 5'd6);
    expect_res("kq_c", 64'd10, 5'd8);

    // Kill while the result is waiting in DONE
    res_ready = 1'b0;
    issue(1'b0, 1'b0, 1'b0, 5'd9, 64'd100, 64'd7);
    wait_res("kd", lat);
    chk("kd_we_before", 64'(res_makes_rd), 64'd1);
    commit_kill[9] = 1'b1;
    #1;
    chk("kd_we_masked", 64'(res_makes_rd), 64'd0);
    tick();
    commit_kill = '0;
    chk("kd_valid_drop", 64'(res_valid), 64'd0);
    chk("kd_busy", 64'(busy), 64'd0);
    res_ready = 1'b1;

    // Reset in the middle of an operation
    issue(1'b0, 1'b0, 1'b0, 5'd10, 64'd100, 64'd7);
    tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mrst_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    chk("mrst_no_result", 64'(seen), 64'd0);

    run_op("post_rst_divu", 1'b0, 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
